input_conditioner: RTL and testbench

Front-end stage between the raw `ui_in` pins and the VGA control path. It synchronizes and debounces all eight user inputs and produces clean levels plus single-cycle edge pulses. It also derives the pause/resume request strobes and the priority-encoded 3-bit speed value consumed by the speed controller. It replaces the direct, unconditioned decoding of `ui_in` in the top level.

---
 rtl/watpixels_pkg.sv | 38 +++
 rtl/input_conditioner_if.sv | 35 +++
 rtl/debounce_bit.sv | 63 ++++++
 rtl/input_conditioner.sv | 46 ++++
 tb/tb_input_conditioner.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/watpixels_pkg.sv
// Shared constants for the watpixels user-input path: pin indices, default speed and
// debounce length, plus the speed-switch priority encoder.
package watpixels_pkg;

  localparam int unsigned PAUSE_BIT  = 0;
  localparam int unsigned RESUME_BIT = 1;
  localparam int unsigned SPEED1_BIT = 2;
  localparam int unsigned SPEED2_BIT = 3;
  localparam int unsigned SPEED3_BIT = 4;
  localparam int unsigned SPEED4_BIT = 5;
  localparam int unsigned SPEED5_BIT = 6;
  localparam int unsigned SPEED6_BIT = 7;

  localparam logic [2:0] SPEED_DEFAULT = 3'd1;

  // About 10 ms at the 25.175 MHz pixel clock.
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 250000;

  // Highest set switch wins. The speed-1 switch is not consulted because it
  // selects the fallback value anyway.
  function automatic logic [2:0] speed_encode(input logic [SPEED6_BIT:SPEED2_BIT] sw);
    logic [2:0] s;
    s = SPEED_DEFAULT;
    if (sw[SPEED6_BIT]) begin
      s = 3'd6;
    end else if (sw[SPEED5_BIT]) begin
      s = 3'd5;
    end else if (sw[SPEED4_BIT]) begin
      s = 3'd4;
    end else if (sw[SPEED3_BIT]) begin
      s = 3'd3;
    end else if (sw[SPEED2_BIT]) begin
      s = 3'd2;
    end
    return s;
  endfunction

endpackage

// File: rtl/input_conditioner_if.sv
// Bundle of raw pins and conditioned outputs between the pin driver and the
// input conditioner.
interface input_conditioner_if #(
  parameter int unsigned WIDTH = 8
);

  logic [WIDTH-1:0] raw_in;
  logic [WIDTH-1:0] clean;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic             pause_req;
  logic             resume_req;
  logic [2:0]       speed;

  modport master (
    output raw_in,
    input  clean,
    input  rise,
    input  fall,
    input  pause_req,
    input  resume_req,
    input  speed
  );

  modport slave (
    input  raw_in,
    output clean,
    output rise,
    output fall,
    output pause_req,
    output resume_req,
    output speed
  );

endinterface

// File: rtl/debounce_bit.sv
// One input bit: two-flop synchronizer, stability counter, debounced level and
// registered single-cycle edge pulses.
module debounce_bit #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic clean,
  output logic rise,
  output logic fall
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic            s1_q, s2_q;
  logic            clean_q, clean_d;
  logic            rise_q, rise_d;
  logic            fall_q, fall_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Any return to the clean level restarts the count, so bounces never accumulate.
  always_comb begin
    cnt_d   = cnt_q;
    clean_d = clean_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (s2_q == clean_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      cnt_d   = '0;
      clean_d = s2_q;
      rise_d  = s2_q;
      fall_d  = ~s2_q;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      cnt_q   <= '0;
      clean_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      s1_q    <= raw;
      s2_q    <= s1_q;
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign clean = clean_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/input_conditioner.sv
// Debounces all user pins and derives the pause/resume strobes and the speed
// value for the VGA control path.
module input_conditioner
  import watpixels_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned WIDTH           = 8
) (
  input logic                clk,
  input logic                rst_n,
  input_conditioner_if.slave bus
);

  logic [WIDTH-1:0] clean_w;
  logic [WIDTH-1:0] rise_w;
  logic [WIDTH-1:0] fall_w;
  logic [7:0]       sw;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce_bit (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (bus.raw_in[i]),
      .clean(clean_w[i]),
      .rise (rise_w[i]),
      .fall (fall_w[i])
    );
  end

  assign bus.clean = clean_w;
  assign bus.rise  = rise_w;
  assign bus.fall  = fall_w;

  // Pause takes precedence when both buttons are accepted on the same edge.
  assign bus.pause_req  = rise_w[PAUSE_BIT];
  assign bus.resume_req = rise_w[RESUME_BIT] & ~rise_w[PAUSE_BIT];

  assign sw = 8'(clean_w);

  always_comb begin
    bus.speed = speed_encode(sw[SPEED6_BIT:SPEED2_BIT]);
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner with a 4-cycle debounce window.
module tb_input_conditioner;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  input_conditioner_if #(.WIDTH(8)) bus ();

  input_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .WIDTH          (8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    string       name;
    int          lat;
    logic [28:0] val;
  } exp_t;

  exp_t sbq[$];
  exp_t x;
  int   tests = 0;
  int   fails = 0;
  int   e;

  function automatic logic [28:0] pk(input logic [7:0] c, input logic [7:0] r,
                                     input logic [7:0] f, input logic p, input logic rs,
                                     input logic [2:0] s);
    return {c, r, f, p, rs, s};
  endfunction

  function automatic logic [28:0] snap();
    return {bus.clean, bus.rise, bus.fall, bus.pause_req, bus.resume_req, bus.speed};
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Steps until any edge pulse appears; edges = -1 when the budget runs out.
  task automatic wait_pulse(input int max_edges, output int edges);
    edges = -1;
    for (int k = 1; k <= max_edges; k++) begin
      step();
      if ((bus.rise | bus.fall) != 8'h00) begin
        edges = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    bus.raw_in = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      step();
      tests++;
      if (snap() !== pk(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 3'd1)) begin
        fails++;
        $display("FAIL reset_hold[%0d]: got %h, want %h", i, snap(),
                 pk(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 3'd1));
      end
    end
    rst_n = 1'b1;
    sbq.push_back('{"reset_release", 6, pk(8'hFF, 8'hFF, 8'h00, 1'b1, 1'b0, 3'd6)});
    wait_pulse(10, e);
    x = sbq.pop_front();
    tests++;
    if (e !== x.lat) begin
      fails++;
      $display("FAIL %s latency: got %0d edges, want %0d", x.name, e, x.lat);
    end
    tests++;
    if (snap() !== x.val) begin
      fails++;
      $display("FAIL %s outputs: got %h, want %h", x.name, snap(), x.val);
    end
    step();
    tests++;
    if (snap() !== pk(8'hFF, 8'h00, 8'h00, 1'b0, 1'b0, 3'd6)) begin
      fails++;
      $display("FAIL reset_pulse_end: got %h, want %h", snap(),
               pk(8'hFF, 8'h00, 8'h00, 1'b0, 1'b0, 3'd6));
    end
  endtask

  task automatic test_latency();
    bus.raw_in = 8'h00;
    sbq.push_back('{"fall_all", 6, pk(8'h00, 8'h00, 8'hFF, 1'b0, 1'b0, 3'd1)});
    wait_pulse(10, e);
    x = sbq.pop_front();
    tests++;
    if (e !== x.lat) begin
      fails++;
      $display("FAIL %s latency: got %0d edges, want %0d", x.name, e, x.lat);
    end
    tests++;
    if (snap() !== x.val) begin
      fails++;
      $display("FAIL %s outputs: got %h, want %h", x.name, snap(), x.val);
    end
    bus.raw_in = 8'h01;
    sbq.push_back('{"pause_rise", 6, pk(8'h01, 8'h01, 8'h00, 1'b1, 1'b0, 3'd1)});
    wait_pulse(10, e);
    x = sbq.pop_front();
    tests++;
    if (e !== x.lat) begin
      fails++;
      $display("FAIL %s latency: got %0d edges, want %0d", x.name, e, x.lat);
    end
    tests++;
    if (snap() !== x.val) begin
      fails++;
      $display("FAIL %s outputs: got %h, want %h", x.name, snap(), x.val);
    end
    step();
    tests++;
    if (snap() !== pk(8'h01, 8'h00, 8'h00, 1'b0, 1'b0, 3'd1)) begin
      fails++;
      $display("FAIL pause_one_cycle: got %h, want %h", snap(),
               pk(8'h01, 8'h00, 8'h00, 1'b0, 1'b0, 3'd1));
    end
    bus.raw_in = 8'h00;
    sbq.push_back('{"pause_fall", 6, pk(8'h00, 8'h00, 8'h01, 1'b0, 1'b0, 3'd1)});
    wait_pulse(10, e);
    x = sbq.pop_front();
    tests++;
    if (e !== x.lat) begin
      fails++;
      $display("FAIL %s latency: got %0d edges, want %0d", x.name, e, x.lat);
    end
    tests++;
    if (snap() !== x.val) begin
      fails++;
      $display("FAIL %s outputs: got %h, want %h", x.name, snap(), x.val);
    end
  endtask

  task automatic test_glitch();
    bus.raw_in = 8'h02;
    repeat (3) step();
    bus.raw_in = 8'h00;
    sbq.push_back('{"glitch3", -1, pk(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 3'd1)});
    wait_pulse(12, e);
    x = sbq.pop_front();
    tests++;
    if (e !== x.lat) begin
      fails++;
      $display("FAIL %s pulse seen: got %0d edges, want %0d", x.name, e, x.lat);
    end
    tests++;
    if (snap() !== x.val) begin
      fails++;
      $display("FAIL %s outputs: got %h, want %h", x.name, snap(), x.val);
    end
    bus.raw_in = 8'h02;
    repeat (4) step();
    bus.raw_in = 8'h00;
    // Accepted on edge 6 of the pulse, i.e. two edges after it is released.
    sbq.push_back('{"pulse4_rise", 2, pk(8'h02, 8'h02, 8'h00, 1'b0, 1'b1, 3'd1)});
    sbq.push_back('{"pulse4_fall", 4, pk(8'h00, 8'h00, 8'h02, 1'b0, 1'b0, 3'd1)});
    for (int n = 0; n < 2; n++) begin
      wait_pulse(10, e);
      x = sbq.pop_front();
      tests++;
      if (e !== x.lat) begin
        fails++;
        $display("FAIL %s latency: got %0d edges, want %0d", x.name, e, x.lat);
      end
      tests++;
      if (snap() !== x.val) begin
        fails++;
        $display("FAIL %s outputs: got %h, want %h", x.name, snap(), x.val);
      end
    end
  endtask

  task automatic test_bounce();
    logic [4:0] seq;
    seq = 5'b01101;  // applied LSB first: 1,0,1,1,0
    for (int i = 0; i < 5; i++) begin
      bus.raw_in = {3'b000, seq[i], 4'h0};
      step();
    end
    bus.raw_in = 8'h10;
    sbq.push_back('{"bounce_rise", 6, pk(8'h10, 8'h10, 8'h00, 1'b0, 1'b0, 3'd3)});
    sbq.push_back('{"bounce_single", -1, pk(8'h10, 8'h00, 8'h00, 1'b0, 1'b0, 3'd3)});
    for (int n = 0; n < 2; n++) begin
      wait_pulse(10, e);
      x = sbq.pop_front();
      tests++;
      if (e !== x.lat) begin
        fails++;
        $display("FAIL %s latency: got %0d edges, want %0d", x.name, e, x.lat);
      end
      tests++;
      if (snap() !== x.val) begin
        fails++;
        $display("FAIL %s outputs: got %h, want %h", x.name, snap(), x.val);
      end
    end
    bus.raw_in = 8'h00;
    sbq.push_back('{"bounce_fall", 6, pk(8'h00, 8'h00, 8'h10, 1'b0, 1'b0, 3'd1)});
    wait_pulse(10, e);
    x = sbq.pop_front();
    tests++;
    if (e !== x.lat) begin
      fails++;
      $display("FAIL %s latency: got %0d edges, want %0d", x.name, e, x.lat);
    end
    tests++;
    if (snap() !== x.val) begin
      fails++;
      $display("FAIL %s outputs: got %h, want %h", x.name, snap(), x.val);
    end
  endtask

  task automatic test_simultaneous();
    bus.raw_in = 8'h03;
    sbq.push_back('{"both_rise", 6, pk(8'h03, 8'h03, 8'h00, 1'b1, 1'b0, 3'd1)});
    wait_pulse(10, e);
    x = sbq.pop_front();
    tests++;
    if (e !== x.lat) begin
      fails++;
      $display("FAIL %s latency: got %0d edges, want %0d", x.name, e, x.lat);
    end
    tests++;
    if (snap() !== x.val) begin
      fails++;
      $display("FAIL %s outputs: got %h, want %h", x.name, snap(), x.val);
    end
    bus.raw_in = 8'h00;
    sbq.push_back('{"both_fall", 6, pk(8'h00, 8'h00, 8'h03, 1'b0, 1'b0, 3'd1)});
    wait_pulse(10, e);
    x = sbq.pop_front();
    tests++;
    if (e !== x.lat) begin
      fails++;
      $display("FAIL %s latency: got %0d edges, want %0d", x.name, e, x.lat);
    end
    tests++;
    if (snap() !== x.val) begin
      fails++;
      $display("FAIL %s outputs: got %h, want %h", x.name, snap(), x.val);
    end
  endtask

  task automatic test_speed_priority();
    bus.raw_in = 8'h48;
    sbq.push_back('{"speed5", 6, pk(8'h48, 8'h48, 8'h00, 1'b0, 1'b0, 3'd5)});
    wait_pulse(10, e);
    x = sbq.pop_front();
    tests++;
    if (e !== x.lat) begin
      fails++;
      $display("FAIL %s latency: got %0d edges, want %0d", x.name, e, x.lat);
    end
    tests++;
    if (snap() !== x.val) begin
      fails++;
      $display("FAIL %s outputs: got %h, want %h", x.name, snap(), x.val);
    end
    bus.raw_in = 8'h08;
    sbq.push_back('{"speed2", 6, pk(8'h08, 8'h00, 8'h40, 1'b0, 1'b0, 3'd2)});
    wait_pulse(10, e);
    x = sbq.pop_front();
    tests++;
    if (e !== x.lat) begin
      fails++;
      $display("FAIL %s latency: got %0d edges, want %0d", x.name, e, x.lat);
    end
    tests++;
    if (snap() !== x.val) begin
      fails++;
      $display("FAIL %s outputs: got %h, want %h", x.name, snap(), x.val);
    end
    // Reset lands on edge 3 of a pending change; the count must restart from zero.
    bus.raw_in = 8'h48;
    repeat (2) step();
    rst_n = 1'b0;
    step();
    tests++;
    if (snap() !== pk(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 3'd1)) begin
      fails++;
      $display("FAIL midcount_reset: got %h, want %h", snap(),
               pk(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 3'd1));
    end
    rst_n = 1'b1;
    sbq.push_back('{"after_reset", 6, pk(8'h48, 8'h48, 8'h00, 1'b0, 1'b0, 3'd5)});
    wait_pulse(10, e);
    x = sbq.pop_front();
    tests++;
    if (e !== x.lat) begin
      fails++;
      $display("FAIL %s latency: got %0d edges, want %0d", x.name, e, x.lat);
    end
    tests++;
    if (snap() !== x.val) begin
      fails++;
      $display("FAIL %s outputs: got %h, want %h", x.name, snap(), x.val);
    end
  endtask

  initial begin
    bus.raw_in = 8'h00;
    test_reset();
    test_latency();
    test_glitch();
    test_bounce();
    test_simultaneous();
    test_speed_priority();
    tests++;
    if (sbq.size() !== 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d left, want 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
